// File: rtl/jtpopeye_objdma.sv
// Sprite DMA: requests the Z80 bus during vertical blank and copies the 4-byte sprite entries into the object buffer.
// Optional feature macro JTPOPEYE_OBJDMA_CHKSUM_EN adds the chksum[7:0] output.
module jtpopeye_objdma #(
  parameter int                ENTRIES  = 128,
  parameter int                ENTRY_AW = 7,
  parameter int                SRC_AW   = 10,
  parameter logic [SRC_AW-1:0] SRC_BASE = 10'h000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic                start,
  input  logic                VB,
  output logic                busrq_n,
  input  logic                busak_n,
  output logic [SRC_AW-1:0]   src_addr,
  input  logic [7:0]          src_data,
  output logic [ENTRY_AW-1:0] buf_addr,
  output logic [28:0]         buf_data,
  output logic                buf_we,
  output logic                busy,
  output logic                done
`ifdef JTPOPEYE_OBJDMA_CHKSUM_EN
  ,
  output logic [7:0]          chksum
`endif
);

`ifdef JTPOPEYE_OBJDMA_CHKSUM_EN
  localparam int B3_W = 8;
`else
  localparam int B3_W = 5;
`endif

  typedef enum logic [3:0] {IDLE, WAITVB, REQ, RD0, RD1, RD2, RD3, WR, REL} state_t;

  state_t              state, state_nx;
  logic                pending;
  logic [ENTRY_AW-1:0] entry;
  logic                last;
  logic [1:0]          rd_k;
  logic                in_rd;
  logic                frozen;

  // tag/tag_vld remember which RDk address the RAM sampled on the previous cen edge
  logic                tag_vld;
  logic [1:0]          tag;
  logic [7:0]          b0, b1, b2;
  logic [B3_W-1:0]     b3, b3_cur;

  assign last   = (entry == ENTRY_AW'(ENTRIES - 1));
  assign frozen = busak_n;
  assign b3_cur = (tag_vld && tag == 2'd3) ? src_data[B3_W-1:0] : b3;

  always_comb begin
    rd_k  = 2'd0;
    in_rd = 1'b0;
    case (state)
      RD0: begin rd_k = 2'd0; in_rd = 1'b1; end
      RD1: begin rd_k = 2'd1; in_rd = 1'b1; end
      RD2: begin rd_k = 2'd2; in_rd = 1'b1; end
      RD3: begin rd_k = 2'd3; in_rd = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pending) state_nx = WAITVB;
      WAITVB:  if (VB) state_nx = REQ;
      REQ:     if (!busak_n) state_nx = RD0;
      RD0:     if (!frozen) state_nx = RD1;
      RD1:     if (!frozen) state_nx = RD2;
      RD2:     if (!frozen) state_nx = RD3;
      RD3:     if (!frozen) state_nx = WR;
      WR:      if (!frozen) state_nx = last ? REL : RD0;
      REL:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busrq_n  = !(state == REQ || in_rd || state == WR);
    busy     = (state != IDLE) && (state != REL);
    done     = (state == REL);
    src_addr = SRC_BASE + (SRC_AW'(entry) << 2) + SRC_AW'(rd_k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      entry    <= '0;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      tag_vld  <= 1'b0;
`ifdef JTPOPEYE_OBJDMA_CHKSUM_EN
      chksum   <= 8'h00;
`endif
    end else begin
      if (cen && state == IDLE && pending)
        pending <= 1'b0;
      else if (start && state == IDLE)
        pending <= 1'b1;

      if (cen) begin
        state   <= state_nx;
        buf_we  <= 1'b0;
        // byte capture: src_data reflects the address of the previous cen cycle
        if (tag_vld) begin
          case (tag)
            2'd0:    b0 <= src_data;
            2'd1:    b1 <= src_data;
            2'd2:    b2 <= src_data;
            default: b3 <= src_data[B3_W-1:0];
          endcase
        end
        tag_vld <= in_rd;
        tag     <= rd_k;
`ifdef JTPOPEYE_OBJDMA_CHKSUM_EN
        if (state == WAITVB && VB)
          chksum <= 8'h00;
        else if (state == WR && !frozen)
          chksum <= chksum + b0 + b1 + b2 + b3_cur;
`endif
        // entry commit
        if (state == WR && !frozen) begin
          buf_we   <= 1'b1;
          buf_addr <= entry;
          buf_data <= {b3_cur[4:0], b2, b1, b0};
          entry    <= last ? '0 : entry + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Scoreboard bench for jtpopeye_objdma: expected buffer writes are queued per run and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_jtpopeye_objdma;
  logic        clk = 1'b0;
  logic        rst, cen, start, VB, busak_n, busrq_n, buf_we, busy, done;
  logic [9:0]  src_addr;
  logic [7:0]  src_data;
  logic [6:0]  buf_addr;
  logic [28:0] buf_data;
`ifdef JTPOPEYE_OBJDMA_CHKSUM_EN
  logic [7:0]  chksum;
`endif

  logic [7:0]  mem [1024];
  logic [28:0] got [128];
  logic        d1, d2, force_hi, edge_cen;
  int          n_chk = 0, n_fail = 0, wr_cnt = 0, done_cnt = 0, cyc = 0, len = 0;

  typedef struct packed {logic [6:0] a; logic [28:0] d;} wr_t;
  wr_t q[$];

  always #5 clk = ~clk;

  jtpopeye_objdma dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .VB(VB),
    .busrq_n(busrq_n), .busak_n(busak_n), .src_addr(src_addr), .src_data(src_data),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we), .busy(busy), .done(done)
`ifdef JTPOPEYE_OBJDMA_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  // bus acknowledge follows the request two cen cycles later; source RAM has one cen of latency
  assign busak_n = d2 | force_hi;
  always @(posedge clk) begin
    if (rst) begin
      d1 <= 1'b1;
      d2 <= 1'b1;
    end else if (cen) begin
      d1 <= busrq_n;
      d2 <= d1;
    end
  end
  always @(posedge clk) if (cen) src_data <= mem[src_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    edge_cen = cen;
    @(posedge clk);
    #1;
    if (edge_cen) len++;
    cyc++;
    cen = (cyc % 3) != 2;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (cen && done) done_cnt++;
      if (cen && buf_we) begin
        wr_cnt++;
        got[buf_addr] = buf_data;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %h, expected no write", buf_addr, buf_data);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_addr", 64'(buf_addr), 64'(e.a));
          chk("wr_data", 64'(buf_data), 64'(e.d));
        end
      end
    end
  endtask

  task automatic push_run();
    wr_t e;
    for (int i = 0; i < 128; i++) begin
      e.a = 7'(i);
      e.d = {mem[4*i+3][4:0], mem[4*i+2], mem[4*i+1], mem[4*i]};
      q.push_back(e);
    end
    for (int i = 0; i < 128; i++) got[i] = '0;
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    len = 0;
  endtask

  task automatic wait_done(input string name, output int run_len);
    int k = 0;
    run_len = 0;
    while (!done && k < 5000) begin step(); k++; end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no done pulse, expected one within 5000 cycles", name);
    end else begin
      run_len = len;
      k = 0;
      while (done && k < 20) begin step(); k++; end
    end
  endtask

  task automatic wait_addr(input string name, input logic [9:0] a);
    int k = 0;
    while (!(src_addr == a && !busrq_n) && k < 5000) begin step(); k++; end
    if (k >= 5000) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no read of address %0h, expected one", name, a);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected end");
    $fatal(1);
  end

  initial begin
    int l0, l1, l2, l3, seen, k;
    rst = 1'b1; start = 1'b0; VB = 1'b0; force_hi = 1'b0; cen = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    fork monitor(); join_none
    repeat (4) step();
    rst = 1'b0;
    step();
    chk("rst_busrq_n", 64'(busrq_n), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_buf_we", 64'(buf_we), 64'(0));
    chk("rst_src_addr", 64'(src_addr), 64'(0));
    chk("rst_buf_addr", 64'(buf_addr), 64'(0));
    chk("rst_buf_data", 64'(buf_data), 64'(0));

    // plain run: 2 cen to REQ, 3 cen handshake, 640 cen of transfer
    VB = 1'b1;
    push_run();
    pulse_start();
    wait_done("run1", l0);
    chk("run1_len", 64'(l0), 64'(645));
    chk("run1_writes", 64'(wr_cnt), 64'(128));
    chk("run1_done_cnt", 64'(done_cnt), 64'(1));
    chk("run1_queue_left", 64'(q.size()), 64'(0));
    chk("run1_busrq_n", 64'(busrq_n), 64'(1));
    chk("run1_busy", 64'(busy), 64'(0));
    chk("run1_entry0", 64'(got[0]), 64'(29'h0302_0100));
    chk("run1_entry127", 64'(got[127]), 64'(29'h1FFE_FDFC));

    // start outside blanking waits; VB drops mid-transfer without aborting
    VB = 1'b0;
    push_run();
    pulse_start();
    seen = 0;
    while (len < 50) begin step(); if (!busrq_n) seen = 1; end
    chk("vb0_busrq_low_seen", 64'(seen), 64'(0));
    chk("vb0_busy", 64'(busy), 64'(1));
    VB = 1'b1;
    k = 0;
    do begin step(); k++; end while (!edge_cen && k < 10);
    chk("vb1_busrq_n", 64'(busrq_n), 64'(0));
    repeat (300) step();
    VB = 1'b0;
    wait_done("vbfall", l1);
    chk("vbfall_writes", 64'(wr_cnt), 64'(128));
    chk("vbfall_done_cnt", 64'(done_cnt), 64'(1));
    VB = 1'b1;

    // bus taken back for 7 cen in RD2 of entry 10
    push_run();
    pulse_start();
    wait_addr("frz_addr", 10'd42);
    force_hi = 1'b1;
    k = 0;
    while (k < 7) begin step(); if (edge_cen) k++; end
    force_hi = 1'b0;
    wait_done("frz", l1);
    chk("frz_len", 64'(l1), 64'(652));
    chk("frz_entry10", 64'(got[10]), 64'(29'h0B2A_2928));
    chk("frz_writes", 64'(wr_cnt), 64'(128));

    // second start during a run is dropped
    push_run();
    pulse_start();
    wait_addr("start2_addr", 10'd160);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("start2", l2);
    chk("start2_len", 64'(l2), 64'(645));
    chk("start2_writes", 64'(wr_cnt), 64'(128));
    seen = 0;
    repeat (30) begin step(); if (busy || !busrq_n) seen = 1; end
    chk("start2_no_requeue", 64'(seen), 64'(0));
    chk("start2_done_cnt", 64'(done_cnt), 64'(1));

    // reset in the middle of the table
    push_run();
    pulse_start();
    k = 0;
    while (wr_cnt < 64 && k < 5000) begin step(); k++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busrq_n", 64'(busrq_n), 64'(1));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_buf_we", 64'(buf_we), 64'(0));
    chk("midrst_writes", 64'(wr_cnt), 64'(64));
    q.delete();
    step();
    push_run();
    pulse_start();
    wait_done("afterrst", l3);
    chk("afterrst_len", 64'(l3), 64'(645));
    chk("afterrst_writes", 64'(wr_cnt), 64'(128));
    chk("afterrst_done_cnt", 64'(done_cnt), 64'(1));
    chk("afterrst_entry127", 64'(got[127]), 64'(29'h1FFE_FDFC));

`ifdef JTPOPEYE_OBJDMA_CHKSUM_EN
    for (int i = 0; i < 1024; i++) mem[i] = 8'h01;
    push_run();
    pulse_start();
    wait_done("cks01", l3);
    chk("chksum_01", 64'(chksum), 64'(8'h00));
    for (int i = 0; i < 1024; i++) mem[i] = 8'h03;
    push_run();
    pulse_start();
    wait_done("cks03", l3);
    chk("chksum_03", 64'(chksum), 64'(8'h00));
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[5] = 8'hA5;
    push_run();
    pulse_start();
    wait_done("ckA5", l3);
    chk("chksum_A5", 64'(chksum), 64'(8'hA5));
`endif

    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
